// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU program-counter slice.
//   WORD_W        : Hack machine word / address width
//   JNULL .. JMP  : C-instruction jump codes {j1,j2,j3} = {lt,eq,gt}
//   is_uncond_jmp : true for the unconditional jump code (used by the halt idiom)
package hack_pkg;

  localparam int WORD_W = 16;

  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  function automatic logic is_uncond_jmp(input logic [2:0] code);
    return code == JMP;
  endfunction

endpackage

// File: rtl/hack_pc_jump_cond.sv
// Combinational jump-condition decoder.
//   jump       in  {j1,j2,j3} = {lt,eq,gt} bits of the C-instruction
//   zr, ng     in  ALU flags (zero, negative)
//   is_c_instr in  current instruction is a C-instruction
//   take_jump  out jump condition holds for the current instruction
module jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  input  logic       is_c_instr,
  output logic       take_jump
);

  logic lt_term;
  logic eq_term;
  logic gt_term;

  assign lt_term = jump[2] & ng;
  assign eq_term = jump[1] & zr;
  // The ALU never reports zr and ng together; if it does, the value is
  // treated as zero for "greater than" only, so zr alone kills the gt term
  // while the lt term still follows ng.
  assign gt_term = jump[0] & ~ng & ~zr;

  assign take_jump = is_c_instr & (lt_term | eq_term | gt_term);

endmodule

// File: rtl/hack_pc.sv
// Hack CPU program-counter stage.
//   clk, rst_n  in  clock, asynchronous active-low reset
//   clr         in  synchronous clear (Hack reset button), wins over en
//   en          in  advance enable; 0 holds all state
//   is_c_instr  in  current instruction is a C-instruction
//   jump        in  jump bits {lt,eq,gt}
//   zr, ng      in  ALU flags
//   a_reg       in  A-register value, the jump target
//   pc          out registered program counter / ROM address
//   take_jump   out combinational jump decision
//   halted      out sticky end-of-program idiom detector
//   jump_cnt    out saturating count of taken jumps
module hack_pc
  import hack_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int INC_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             is_c_instr,
  input  logic [2:0]       jump,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] pc,
  output logic             take_jump,
  output logic             halted,
  output logic [7:0]       jump_cnt
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             halted_q;
  logic             halted_d;
  logic [7:0]       jump_cnt_q;
  logic [7:0]       jump_cnt_d;
  logic [WIDTH-1:0] pc_prev;
  logic             self_loop;

  jump_cond u_jump_cond (
    .jump       (jump),
    .zr         (zr),
    .ng         (ng),
    .is_c_instr (is_c_instr),
    .take_jump  (take_jump)
  );

  // The `@END; 0;JMP` idiom jumps back either onto itself or onto the
  // preceding A-instruction, so both pc and pc-1 count as a self loop.
  assign pc_prev   = pc_q - WIDTH'(1);
  assign self_loop = (a_reg == pc_q) || (a_reg == pc_prev);

  always_comb begin
    pc_d       = pc_q;
    halted_d   = halted_q;
    jump_cnt_d = jump_cnt_q;
    if (clr) begin
      pc_d       = '0;
      halted_d   = 1'b0;
      jump_cnt_d = '0;
    end else if (en) begin
      if (take_jump) begin
        pc_d = a_reg;
        if (jump_cnt_q != 8'hFF) begin
          jump_cnt_d = jump_cnt_q + 8'd1;
        end
        if (is_uncond_jmp(jump) && self_loop) begin
          halted_d = 1'b1;
        end
      end else begin
        pc_d = pc_q + WIDTH'(INC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      halted_q   <= 1'b0;
      jump_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      jump_cnt_q <= jump_cnt_d;
    end
  end

  assign pc       = pc_q;
  assign halted   = halted_q;
  assign jump_cnt = jump_cnt_q;

endmodule

// File: doc/hack_pc.md
Name: hack_pc

Overview:
- Program-counter stage of the Hack CPU.
- Consumes the OR-reduced jump condition, formed from the jump bits of the C-instruction and the ALU flags.
- Each cycle it selects one of: clear, hold, load A-register, or increment.
- Drives the instruction-ROM address.
- Also provides a sticky halt indicator that detects the Hack end-of-program idiom (`@END; 0;JMP`).

Parameters:
- WIDTH, 16, PC, A-register and ROM address width.
- INC_STEP, 1, increment amount per non-jump cycle.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset. Asynchronous, active-low; clears pc, halted and jump_cnt.
- clr  input  1  synchronous clear (Hack "reset" button); pc<=0 on the next edge.
- en  input  1  advance enable; 0 = stall, all state held.
- is_c_instr  input  1  current instruction is a C-instruction (instr[15]).
- jump  input  3  jump bits {j1,j2,j3} = {lt,eq,gt}.
- zr  input  1  ALU output == 0.
- ng  input  1  ALU output < 0.
- a_reg  input  WIDTH  current A-register value (jump target).
- pc  output  WIDTH  registered program counter / ROM address.
- take_jump  output  1  combinational: jump condition true for the current instruction.
- halted  output  1  registered, sticky: halt idiom detected.
- jump_cnt  output  8  registered, saturating count of taken jumps (debug).

Behaviour:
- Reset (rst_n=0, asynchronous): pc=0, halted=0, jump_cnt=0. Outputs are valid immediately, with no clock needed.
- take_jump = is_c_instr & ((jump[2]&ng) | (jump[1]&zr) | (jump[0]&~ng&~zr)).
  - Purely combinational; ignores en and clr.
  - zr=1 with ng=1 is illegal from the ALU. In that case treat the value as zero for the gt term only: the gt term is suppressed and the lt term is still honoured.
- Next-pc priority, evaluated at each rising edge:
  1. clr=1: pc<=0, halted<=0, jump_cnt<=0. Wins over en=0.
  2. en=0: hold all state.
  3. take_jump=1: pc<=a_reg.
  4. otherwise: pc<=pc+INC_STEP, mod 2^WIDTH. 0xFFFF wraps to 0x0000; no flag is raised.
- Latency: the new pc is visible one cycle after the deciding edge. The bypass path is combinational only; there is no additional pipeline.
- halted is set on an edge where all of the following hold, and is only cleared by clr or rst_n:
  - en=1 and clr=0;
  - take_jump=1 and jump=3'b111;
  - a_reg equals pc or pc-1 (mod 2^WIDTH).
- After halted is set, the pc keeps executing the loop; halted does not gate en.
- jump_cnt increments on every edge with en=1, clr=0 and take_jump=1. It saturates at 255.
- An A-instruction (is_c_instr=0) never jumps, whatever the jump bits are.
- If rst_n is asserted mid-stall or mid-jump, it overrides everything asynchronously. Normal operation resumes from 0 on the first edge after release.

Decomposition:
- Shared package `hack_pkg`:
  - WORD_W=16;
  - jump-code constants JNULL=3'b000, JGT=3'b001, JEQ=3'b010, JGE=3'b011, JLT=3'b100, JNE=3'b101, JLE=3'b110, JMP=3'b111.
- One natural sub-module: `jump_cond`, combinational. Inputs: jump, zr, ng, is_c_instr. Output: take_jump. It is built from the team's AND/OR/NOT primitives.
- Counter, halt detector and saturating jump counter stay in `hack_pc`.

Test Plan:
- Reset and increment: rst_n low then high, en=1, no jumps, 5 edges -> pc=0,1,2,3,4,5; halted=0; jump_cnt=0.
- Jump decode sweep: for all 8 jump codes × {(zr,ng)=(0,0),(1,0),(0,1)} with is_c_instr=1 and a_reg=0x0100 -> take_jump matches the truth table (e.g. JGE with ng=1 gives 0; JNE with zr=0 gives 1). A taken jump gives pc=0x0100 next edge and jump_cnt increments.
- Priority and stall: pc=0x0010, en=0, take_jump=1 -> pc stays 0x0010. Then clr=1 with en=0 -> pc=0. Then is_c_instr=0, jump=111 -> pc increments to 1.
- Wrap-around: load a_reg=0xFFFF via JMP, then one non-jump edge -> pc=0x0000, no error.
- Halt idiom: pc=0x0021, a_reg=0x0020, jump=111 -> halted=1 after edge, pc=0x0020. Loop for 3 iterations -> halted stays 1. Then clr -> halted=0, pc=0.
- Async reset mid-run and counter saturation: 300 consecutive taken jumps -> jump_cnt=255. Drop rst_n between edges -> pc, halted and jump_cnt read 0 before the next clk edge.
